// File: rtl/soc_io_pkg.sv
// Shared definitions for the SoC UART/GPIO I/O block: register map,
// STATUS bit positions and UART FSM encodings.
package soc_io_pkg;

  localparam logic [1:0] REG_TX_DATA = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_RX_DATA = 2'd2;
  localparam logic [1:0] REG_GPIO    = 2'd3;

  localparam int unsigned ST_FIFO_FULL    = 0;
  localparam int unsigned ST_FIFO_EMPTY   = 1;
  localparam int unsigned ST_TX_BUSY      = 2;
  localparam int unsigned ST_RX_VALID     = 3;
  localparam int unsigned ST_RX_OVERRUN   = 4;
  localparam int unsigned ST_TX_DROP      = 5;
  localparam int unsigned ST_RX_FRAME_ERR = 6;
  localparam int unsigned ST_COUNT_LSB    = 8;
  localparam int unsigned ST_COUNT_W      = 8;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read; a push while full is
// accepted only when a pop happens on the same edge.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push_c;
  logic             do_pop_c;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign rdata     = mem[rd_ptr];
  assign do_pop_c  = pop & ~empty;
  assign do_push_c = push & (~full | do_pop_c);

  // Storage needs no reset; pointers define what is valid.
  always_ff @(posedge CLK) begin
    if (do_push_c) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop_c)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push_c) - CW'(do_pop_c);
    end
  end

endmodule

// File: rtl/soc_uart_io.sv
// Memory-mapped UART (TX FIFO, single-byte RX buffer) and GPIO output
// register on the CPU data bus.
module soc_uart_io
  import soc_io_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50000000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned IO_BIT      = 22,
  parameter int unsigned GPIO_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic [3:0]            mem_wmask,
  input  logic                  mem_rstrb,
  output logic                  io_sel,
  output logic [31:0]           io_rdata,
  input  logic                  RXD,
  output logic                  TXD,
  output logic [GPIO_WIDTH-1:0] gpio_out
);

  localparam int unsigned DIV   = CLK_FREQ_HZ / BAUD;
  localparam int unsigned HALF  = DIV / 2;
  localparam int unsigned CNT_W = $clog2(DIV);
  localparam int unsigned FC_W  = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]      reg_off;
  logic            rd_c;
  logic            push_c;
  logic            gpio_wr_c;
  logic            rd_status_c;
  logic            rd_rxdata_c;
  logic [31:0]     lane_mask_c;
  logic [31:0]     status_c;
  logic            unused_bus;

  logic [7:0]      fifo_rdata;
  logic            fifo_full;
  logic            fifo_empty;
  logic [FC_W-1:0] fifo_count;
  logic            tx_pop_c;
  logic            tx_drop;

  tx_state_t       tx_state;
  logic [CNT_W-1:0] tx_cnt;
  logic [2:0]      tx_bit;
  logic [7:0]      tx_shift;
  logic            tx_tick_c;

  rx_state_t       rx_state;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_shift;
  logic [7:0]      rx_byte;
  logic            rx_valid;
  logic            rx_overrun;
  logic            rx_frame_err;
  logic            rxd_meta;
  logic            rxd_sync;
  logic            rxd_prev;
  logic            rx_tick_c;

  // Bus decode
  assign io_sel      = mem_addr[IO_BIT];
  assign reg_off     = mem_addr[3:2];
  assign rd_c        = io_sel & mem_rstrb;
  assign push_c      = io_sel & mem_wmask[0] & (reg_off == REG_TX_DATA);
  assign gpio_wr_c   = io_sel & (|mem_wmask) & (reg_off == REG_GPIO);
  assign rd_status_c = rd_c & (reg_off == REG_STATUS);
  assign rd_rxdata_c = rd_c & (reg_off == REG_RX_DATA);
  assign lane_mask_c = {{8{mem_wmask[3]}}, {8{mem_wmask[2]}},
                        {8{mem_wmask[1]}}, {8{mem_wmask[0]}}};
  assign unused_bus  = ^{mem_addr, mem_wdata};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .CLK   (CLK),
    .RESET (RESET),
    .push  (push_c),
    .wdata (mem_wdata[7:0]),
    .pop   (tx_pop_c),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    status_c                                 = '0;
    status_c[ST_FIFO_FULL]                   = fifo_full;
    status_c[ST_FIFO_EMPTY]                  = fifo_empty;
    status_c[ST_TX_BUSY]                     = ~fifo_empty | (tx_state != TX_IDLE);
    status_c[ST_RX_VALID]                    = rx_valid;
    status_c[ST_RX_OVERRUN]                  = rx_overrun;
    status_c[ST_TX_DROP]                     = tx_drop;
    status_c[ST_RX_FRAME_ERR]                = rx_frame_err;
    status_c[ST_COUNT_LSB +: ST_COUNT_W]     = ST_COUNT_W'(fifo_count);
  end

  // Read data register and GPIO; a new sticky event wins over a same-edge clear
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      io_rdata <= '0;
      gpio_out <= '0;
      tx_drop  <= 1'b0;
    end else begin
      if (rd_c) begin
        case (reg_off)
          REG_STATUS:  io_rdata <= status_c;
          REG_RX_DATA: io_rdata <= 32'(rx_byte);
          REG_GPIO:    io_rdata <= 32'(gpio_out);
          default:     io_rdata <= '0;
        endcase
      end
      if (gpio_wr_c)
        gpio_out <= (gpio_out & ~lane_mask_c[GPIO_WIDTH-1:0]) |
                    (mem_wdata[GPIO_WIDTH-1:0] & lane_mask_c[GPIO_WIDTH-1:0]);
      if (rd_status_c) tx_drop <= 1'b0;
      if (push_c && fifo_full && !tx_pop_c) tx_drop <= 1'b1;
    end
  end

  // TX: pop from IDLE, or from the end of STOP for gap-free back-to-back frames
  assign tx_tick_c = (tx_cnt == CNT_W'(DIV - 1));
  assign tx_pop_c  = ~fifo_empty & ((tx_state == TX_IDLE) |
                                    ((tx_state == TX_STOP) & tx_tick_c));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      TXD      <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_pop_c) begin
            tx_state <= TX_START;
            tx_shift <= fifo_rdata;
            tx_cnt   <= '0;
            TXD      <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_tick_c) begin
            tx_state <= TX_DATA;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            TXD      <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
          end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
          end
        end
        TX_DATA: begin
          if (tx_tick_c) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              tx_state <= TX_STOP;
              TXD      <= 1'b1;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              TXD      <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
            end
          end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
          end
        end
        TX_STOP: begin
          if (tx_tick_c) begin
            tx_cnt <= '0;
            if (tx_pop_c) begin
              tx_state <= TX_START;
              tx_shift <= fifo_rdata;
              TXD      <= 1'b0;
            end else begin
              tx_state <= TX_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
          end
        end
        default: begin
          tx_state <= TX_IDLE;
          TXD      <= 1'b1;
        end
      endcase
    end
  end

  // RXD synchroniser plus one stage of history for edge detection
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= RXD;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  assign rx_tick_c = (rx_cnt == CNT_W'(DIV - 1));

  // RX: mid-bit sampling; an RX_DATA read on the storing edge frees the buffer
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rx_state     <= RX_IDLE;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
      rx_byte      <= '0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      if (rd_rxdata_c) rx_valid <= 1'b0;
      if (rd_status_c) begin
        rx_overrun   <= 1'b0;
        rx_frame_err <= 1'b0;
      end
      case (rx_state)
        RX_IDLE: begin
          if (rxd_prev && !rxd_sync) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt == CNT_W'(HALF - 1)) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rxd_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (rx_tick_c) begin
            rx_cnt   <= '0;
            rx_shift <= {rxd_sync, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (rx_tick_c) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (!rxd_sync) begin
              rx_frame_err <= 1'b1;
            end else if (rx_valid && !rd_rxdata_c) begin
              rx_overrun <= 1'b1;
            end else begin
              rx_byte  <= rx_shift;
              rx_valid <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_soc_uart_io.sv
// Bench for soc_uart_io at DIV=10: register table, directed UART corner
// cases and randomized traffic checked against a frame-level model.
module tb_soc_uart_io;

  localparam int unsigned DIV  = 10;
  localparam int unsigned HALF = 5;
  localparam logic [31:0] IOA  = 32'h0040_0000;
  localparam logic [1:0]  O_TX = 2'd0, O_ST = 2'd1, O_RX = 2'd2, O_GP = 2'd3;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rstrb;
  logic        io_sel;
  logic [31:0] io_rdata;
  logic        RXD;
  logic        TXD;
  logic [7:0]  gpio_out;

  soc_uart_io #(
    .CLK_FREQ_HZ (1000000),
    .BAUD        (100000),
    .FIFO_DEPTH  (16),
    .IO_BIT      (22),
    .GPIO_WIDTH  (8)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_rstrb (mem_rstrb),
    .io_sel    (io_sel),
    .io_rdata  (io_rdata),
    .RXD       (RXD),
    .TXD       (TXD),
    .gpio_out  (gpio_out)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_en = 1'b1;

  typedef struct {
    logic [7:0] b;
    logic       ok;
    int         t;
  } mon_t;
  mon_t       mon_q[$];
  logic [7:0] exp_q[$];

  typedef struct {
    logic        sel;
    logic [1:0]  off;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[9];

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic sel, input logic [1:0] off, input logic [31:0] d,
                           input logic [3:0] m);
    mem_addr  = (sel ? IOA : 32'h0) | {28'h0, off, 2'b00};
    mem_wdata = d;
    mem_wmask = m;
    @(negedge CLK);
    mem_wmask = 4'h0;
  endtask

  task automatic bus_read(input logic [1:0] off, output logic [31:0] d);
    mem_addr  = IOA | {28'h0, off, 2'b00};
    mem_rstrb = 1'b1;
    @(negedge CLK);
    mem_rstrb = 1'b0;
    d = io_rdata;
  endtask

  task automatic read_check(input string name, input logic [1:0] off, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(off, d);
    check(name, d, exp);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    RXD = 1'b0;
    repeat (DIV) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      repeat (DIV) @(negedge CLK);
    end
    RXD = stop;
    repeat (DIV) @(negedge CLK);
    RXD = 1'b1;
    repeat (2 * DIV) @(negedge CLK);
  endtask

  // Wait for the expected frames, then compare bytes, stop bits and spacing
  task automatic drain_frames(input int budget, input bit contig);
    int n;
    int k;
    int t_prev;
    n = exp_q.size();
    k = 0;
    t_prev = 0;
    while (k < budget && mon_q.size() < n) begin
      @(negedge CLK);
      k++;
    end
    check("frame_count", 32'(mon_q.size()), 32'(n));
    for (int i = 0; i < n && mon_q.size() > 0; i++) begin
      mon_t m;
      m = mon_q.pop_front();
      check($sformatf("frame%0d_byte", i), 32'(m.b), 32'(exp_q[i]));
      check($sformatf("frame%0d_stop", i), 32'(m.ok), 32'd1);
      if (contig && i > 0) check($sformatf("frame%0d_gap", i), 32'(m.t - t_prev), 32'(10 * DIV));
      t_prev = m.t;
    end
    exp_q.delete();
    mon_q.delete();
  endtask

  // Decodes TXD at mid-bit and records each frame's start cycle
  initial begin : tx_mon
    mon_t       m;
    int         t0;
    logic [7:0] b;
    logic       ok;
    b = '0;
    forever begin
      @(negedge CLK);
      if (!RESET && TXD === 1'b0) begin
        t0 = cyc;
        repeat (HALF) @(negedge CLK);
        ok = (TXD == 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge CLK);
          b[i] = TXD;
        end
        repeat (DIV) @(negedge CLK);
        ok = ok & TXD;
        if (mon_en) begin
          m.b = b;
          m.ok = ok;
          m.t = t0;
          mon_q.push_back(m);
        end
      end
    end
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  gm;
    logic [7:0]  rb;
    logic [31:0] wd;
    logic [3:0]  mk;
    int          nbad;
    logic        exp_bit;

    vecs[0] = '{1'b1, O_GP, 32'h1000_00FF, 4'b0001, 32'h0000_00FF};
    vecs[1] = '{1'b1, O_GP, 32'h0000_AA00, 4'b0010, 32'h0000_00FF};
    vecs[2] = '{1'b1, O_GP, 32'h1234_5634, 4'b0001, 32'h0000_0034};
    vecs[3] = '{1'b0, O_GP, 32'h0000_00CC, 4'b0001, 32'h0000_0034};
    vecs[4] = '{1'b1, O_GP, 32'h0000_00CC, 4'b0000, 32'h0000_0034};
    vecs[5] = '{1'b1, O_ST, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0002};
    vecs[6] = '{1'b1, O_RX, 32'h0000_00FF, 4'b1111, 32'h0000_0000};
    vecs[7] = '{1'b1, O_TX, 32'h0000_0041, 4'b0000, 32'h0000_0000};
    vecs[8] = '{1'b1, O_GP, 32'hFFFF_FF00, 4'b0001, 32'h0000_0000};

    RESET = 1'b1;
    mem_addr = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    mem_rstrb = 1'b0;
    RXD = 1'b1;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;

    check("rst_rdata", io_rdata, 32'h0);
    check("rst_txd", 32'(TXD), 32'd1);
    check("rst_gpio", 32'(gpio_out), 32'h0);
    read_check("rst_status", O_ST, 32'h0000_0002);
    check("io_sel_hi", 32'(io_sel), 32'd1);
    mem_addr = 32'h0000_0004;
    mem_rstrb = 1'b1;
    #1;
    check("io_sel_lo", 32'(io_sel), 32'd0);
    @(negedge CLK);
    mem_rstrb = 1'b0;
    check("rd_hold_nosel", io_rdata, 32'h0000_0002);

    for (int i = 0; i < 9; i++) begin
      bus_write(vecs[i].sel, vecs[i].off, vecs[i].wdata, vecs[i].mask);
      bus_read(vecs[i].off, d);
      check($sformatf("vec%0d_rd", i), d, vecs[i].exp);
      if (vecs[i].off == O_GP)
        check($sformatf("vec%0d_gpio", i), 32'(gpio_out), {24'h0, vecs[i].exp[7:0]});
    end
    read_check("vec_status_after", O_ST, 32'h0000_0002);

    // Exact TXD waveform of a single 0x55 frame
    bus_write(1'b1, O_TX, 32'h0000_0055, 4'b0001);
    check("tx55_pre_txd", 32'(TXD), 32'd1);
    nbad = 0;
    for (int i = 0; i < 101; i++) begin
      @(negedge CLK);
      if (i < 10)       exp_bit = 1'b0;
      else if (i < 90)  exp_bit = ((8'h55 >> ((i - 10) / 10)) & 8'h01) != 0;
      else              exp_bit = 1'b1;
      if (TXD !== exp_bit) nbad++;
    end
    check("tx55_wave_bad_cycles", 32'(nbad), 32'd0);
    exp_q.push_back(8'h55);
    drain_frames(300, 1'b0);

    // 18 back-to-back writes: one popped at once, 16 held, the 18th dropped
    mem_addr  = IOA;
    mem_wmask = 4'b0001;
    for (int i = 0; i < 18; i++) begin
      mem_wdata = 32'(8'(i * 13 + 7));
      if (i < 17) exp_q.push_back(8'(i * 13 + 7));
      @(negedge CLK);
    end
    mem_wmask = 4'h0;
    read_check("burst_status_full", O_ST, 32'h0000_1025);
    read_check("burst_status_clr", O_ST, 32'h0000_1005);
    drain_frames(17 * 100 + 300, 1'b1);
    repeat (5) @(negedge CLK);
    read_check("burst_status_done", O_ST, 32'h0000_0002);

    send_rx(8'hA3, 1'b1);
    read_check("rxa3_status", O_ST, 32'h0000_000A);
    read_check("rxa3_data", O_RX, 32'h0000_00A3);
    read_check("rxa3_status_clr", O_ST, 32'h0000_0002);

    send_rx(8'h3C, 1'b1);
    send_rx(8'hC5, 1'b1);
    read_check("ovr_status", O_ST, 32'h0000_001A);
    read_check("ovr_data", O_RX, 32'h0000_003C);
    read_check("ovr_status_clr", O_ST, 32'h0000_0002);

    send_rx(8'h5C, 1'b0);
    read_check("ferr_status", O_ST, 32'h0000_0042);
    read_check("ferr_status_clr", O_ST, 32'h0000_0002);

    RXD = 1'b0;
    repeat (3) @(negedge CLK);
    RXD = 1'b1;
    repeat (4 * DIV) @(negedge CLK);
    read_check("glitch_status", O_ST, 32'h0000_0002);

    for (int i = 0; i < 4; i++) begin
      rb = 8'($urandom_range(0, 255));
      send_rx(rb, 1'b1);
      read_check($sformatf("rand_rx%0d_status", i), O_ST, 32'h0000_000A);
      read_check($sformatf("rand_rx%0d_data", i), O_RX, {24'h0, rb});
    end

    gm = 8'h00;
    for (int i = 0; i < 8; i++) begin
      wd = $urandom;
      mk = 4'($urandom_range(0, 15));
      bus_write(1'b1, O_GP, wd, mk);
      if (mk[0]) gm = wd[7:0];
      check($sformatf("rand_gpio%0d_pin", i), 32'(gpio_out), {24'h0, gm});
      read_check($sformatf("rand_gpio%0d_rd", i), O_GP, {24'h0, gm});
    end

    for (int i = 0; i < 5; i++) begin
      rb = 8'($urandom_range(0, 255));
      exp_q.push_back(rb);
      bus_write(1'b1, O_TX, {24'h0, rb}, 4'b0001);
      repeat ($urandom_range(0, 40)) @(negedge CLK);
    end
    drain_frames(5 * 100 + 300, 1'b0);

    // Reset during the start bit of a frame with more bytes queued
    mon_en = 1'b0;
    bus_write(1'b1, O_TX, 32'h0000_000F, 4'b0001);
    bus_write(1'b1, O_TX, 32'h0000_0033, 4'b0001);
    bus_write(1'b1, O_TX, 32'h0000_0077, 4'b0001);
    repeat (3) @(negedge CLK);
    check("midrst_pre_txd", 32'(TXD), 32'd0);
    #2;
    RESET = 1'b1;
    #1;
    check("midrst_txd", 32'(TXD), 32'd1);
    check("midrst_rdata", io_rdata, 32'h0);
    check("midrst_gpio", 32'(gpio_out), 32'h0);
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    read_check("midrst_status", O_ST, 32'h0000_0002);
    nbad = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge CLK);
      if (TXD !== 1'b1) nbad++;
    end
    check("midrst_txd_idle_cycles_low", 32'(nbad), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/soc_uart_io.md
Name: soc_uart_io

Overview:
- Memory-mapped I/O peripheral on the risc_v CPU data bus (mem_addr/mem_wdata/mem_wmask/mem_rstrb).
- Drives the SoC TXD pin and receives on RXD: parametrised UART TX with FIFO, UART RX with a single-byte buffer, plus a GPIO output register.
- The SoC top routes CPU accesses to this block when io_sel is high; otherwise they go to RAM, and the top muxes io_rdata against RAM read data.

Parameters:
- CLK_FREQ_HZ, 50000000, system clock frequency.
- BAUD, 115200, UART bit rate; DIV = CLK_FREQ_HZ/BAUD (integer, ≥4).
- FIFO_DEPTH, 16, TX FIFO entries; power of two, ≥2.
- IO_BIT, 22, address bit that selects I/O space.
- GPIO_WIDTH, 8, width of the GPIO output register (1..32).

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- mem_addr  in  32  CPU byte address.
- mem_wdata  in  32  CPU write data.
- mem_wmask  in  4  byte write enables; nonzero means write.
- mem_rstrb  in  1  read strobe.
- io_sel  out  1  combinational: mem_addr[IO_BIT].
- io_rdata  out  32  registered read data.
- RXD  in  1  UART receive (asynchronous to CLK).
- TXD  out  1  UART transmit.
- gpio_out  out  GPIO_WIDTH  GPIO register.

Behaviour:
- Reset values: TXD=1, io_rdata=0, gpio_out=0, FIFO empty, all sticky flags 0, TX and RX FSMs in IDLE.
- Register select: word offset mem_addr[3:2], only while io_sel=1.
  - 0 TX_DATA (W): enqueue mem_wdata[7:0] when mem_wmask[0]=1.
  - 1 STATUS (R):
    - bit0 fifo_full, bit1 fifo_empty, bit2 tx_busy (FIFO non-empty or TX FSM not IDLE).
    - bit3 rx_valid, bit4 rx_overrun, bit5 tx_drop, bit6 rx_frame_err.
    - [15:8] fifo_count.
    - Reading STATUS clears bits 4–6 in the same edge that captures them.
  - 2 RX_DATA (R): [7:0] = rx byte; the read clears rx_valid.
  - 3 GPIO (RW): byte-lane writes per mem_wmask; reads return zero-extended gpio_out.
- Read latency is 1 cycle: io_rdata is updated on the CLK edge where mem_rstrb=1 and io_sel=1, and holds otherwise.
- Unmapped offsets and writes to read-only registers are ignored.
- Write to TX_DATA while the FIFO is full: byte dropped, tx_drop set, FIFO unchanged.
- TX FSM, states IDLE→START→DATA→STOP→IDLE, each bit lasting DIV cycles:
  - Leaves IDLE the cycle after the FIFO becomes non-empty, popping the head entry.
  - START drives 0; DATA sends 8 bits LSB first; STOP drives 1.
  - STOP returns directly to START if the FIFO is non-empty (back-to-back frames, no idle gap).
- Simultaneous push and pop with the FIFO full: the pop occurs and the push is accepted; count is unchanged.
- RX front end: 2-FF synchroniser on RXD.
- RX FSM, states IDLE→START→DATA→STOP:
  - A falling edge in IDLE starts a frame.
  - Start bit is sampled at DIV/2; if it is high, return to IDLE (glitch rejection).
  - Data bits are sampled every DIV cycles thereafter.
  - Stop bit = 0: set rx_frame_err and discard the byte.
  - Stop bit = 1: store the byte and set rx_valid.
  - If rx_valid is already 1: keep the old byte and set rx_overrun.
    - Exception: if an RX_DATA read occurs in the same cycle, store the new byte, keep rx_valid=1, and do not flag overrun.
- Baud counters and the FIFO pointers wrap modulo DIV and FIFO_DEPTH; fifo_count has log2(FIFO_DEPTH)+1 bits.
- RESET asserted mid-frame aborts immediately: TXD=1, FIFO flushed, partial RX byte discarded.

Decomposition:
- Package soc_io_pkg:
  - Register offsets TX_DATA/STATUS/RX_DATA/GPIO.
  - STATUS bit indices.
  - TX and RX FSM state encodings.
- Sub-module sync_fifo: parameters WIDTH and DEPTH; outputs full, empty and count; same CLK/RESET.
- The UART FSMs stay inline.

Test Plan (CLK_FREQ_HZ=1000000, BAUD=100000, so DIV=10):
- Reset, then read STATUS → io_rdata=0x00000002 one cycle after the strobe; TXD=1; gpio_out=0.
- Write 0x55 to TX_DATA → TXD low for 10 cycles, then bits 1,0,1,0,1,0,1,0 at 10 cycles each, then high; the whole frame takes 100 cycles.
- Write 17 bytes back-to-back with FIFO_DEPTH=16:
  - The first byte is popped immediately, so 16 remain in the FIFO and the 17th is accepted.
  - An 18th write sets tx_drop.
  - STATUS reads full=1 and count=16; a second STATUS read shows tx_drop=0.
  - The frames on TXD are contiguous with no idle gap.
- Drive the RX frame 0xA3 on RXD → rx_valid=1; an RX_DATA read returns 0x000000A3 and rx_valid clears.
- Send two RX frames without reading → STATUS shows rx_overrun=1; RX_DATA returns the first byte.
- Send an RX frame with the stop bit at 0 → rx_frame_err=1 and rx_valid stays 0.
- Assert a 3-cycle low glitch on RXD → no frame is received.
- Write 0x1_0000FF with mem_wmask=0001 to GPIO → gpio_out=0xFF; a GPIO read returns 0x000000FF.
- Assert RESET mid-TX-frame → TXD=1 immediately and STATUS afterwards reads 0x2.
